// File: rtl/ram_pingpong_sched_if.sv
// Bus bundle between the write controller, the ping-pong scheduler and the
// matrix RAM / reader. The scheduler uses the slave side; the driving
// environment uses the master side.
interface ram_pingpong_sched_if #(
   parameter int DW = 32,
   parameter int SW = 2
);
   // write stream from the write controller
   logic          in_wr_en;
   logic [SW-1:0] in_wr_strb;
   logic [3:0]    in_wr_addr;
   logic [DW-1:0] in_wr_data;
   logic          in_frame_done;
   logic          in_ready;
   // RAM write port
   logic          bank_wr_en;
   logic [SW-1:0] bank_wr_strb;
   logic [4:0]    bank_wr_addr;
   logic [DW-1:0] bank_wr_data;
   // reader handshake and RAM read port
   logic          mat_valid;
   logic          rd_start;
   logic          bank_rd_en;
   logic [4:0]    bank_rd_addr;
   logic          rd_sop;
   logic          rd_eop;
   // sticky overflow flag
   logic          ovf;

   modport slave (
      input  in_wr_en, in_wr_strb, in_wr_addr, in_wr_data, in_frame_done, rd_start,
      output in_ready, bank_wr_en, bank_wr_strb, bank_wr_addr, bank_wr_data,
             mat_valid, bank_rd_en, bank_rd_addr, rd_sop, rd_eop, ovf
   );

   modport master (
      output in_wr_en, in_wr_strb, in_wr_addr, in_wr_data, in_frame_done, rd_start,
      input  in_ready, bank_wr_en, bank_wr_strb, bank_wr_addr, bank_wr_data,
             mat_valid, bank_rd_en, bank_rd_addr, rd_sop, rd_eop, ovf
   );
endinterface

// File: rtl/ram_pingpong_sched.sv
// Ping-pong scheduler: two matrix banks in one 32-entry RAM (bank = addr[4]).
// The writer fills one bank while the reader drains the other; full_cnt
// tracks how many completed banks are waiting or being read.
module ram_pingpong_sched #(
   parameter int DEPTH = 9,
   parameter int DW    = 32,
   parameter int SW    = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   ram_pingpong_sched_if.slave    bus
);
   typedef enum logic {IDLE, READ} rd_state_e;

   localparam logic [3:0] LAST_ENTRY = 4'(DEPTH - 1);

   rd_state_e     state_q, state_d;
   logic [3:0]    entry_q, entry_d;
   logic          rd_bank_q, rd_bank_d;
   logic          wr_bank_q, wr_bank_d;
   logic [1:0]    full_cnt_q, full_cnt_d;
   logic          ovf_q, ovf_d;

   logic          bank_wr_en_q;
   logic [SW-1:0] bank_wr_strb_q;
   logic [4:0]    bank_wr_addr_q;
   logic [DW-1:0] bank_wr_data_q;

   logic ready;
   logic wr_accept;
   logic fd_accept;
   logic reading;
   logic last_beat;
   logic mat_valid;

   // handshake decode, all derived from registered state
   assign ready     = (full_cnt_q != 2'd2);
   assign wr_accept = bus.in_wr_en & ready;
   assign fd_accept = bus.in_frame_done & ready;
   assign reading   = (state_q == READ);
   assign last_beat = reading && (entry_q == LAST_ENTRY);
   assign mat_valid = (state_q == IDLE) && (full_cnt_q != 2'd0);

   assign bus.in_ready     = ready;
   assign bus.mat_valid    = mat_valid;
   assign bus.bank_rd_en   = reading;
   assign bus.bank_rd_addr = reading ? {rd_bank_q, entry_q} : 5'd0;
   assign bus.rd_sop       = reading && (entry_q == 4'd0);
   assign bus.rd_eop       = last_beat;
   assign bus.ovf          = ovf_q;
   assign bus.bank_wr_en   = bank_wr_en_q;
   assign bus.bank_wr_strb = bank_wr_strb_q;
   assign bus.bank_wr_addr = bank_wr_addr_q;
   assign bus.bank_wr_data = bank_wr_data_q;

   // read FSM next state: walk entries 0..DEPTH-1 of rd_bank, then release it
   always_comb begin
      state_d   = state_q;
      entry_d   = entry_q;
      rd_bank_d = rd_bank_q;
      case (state_q)
         IDLE: begin
            if (bus.rd_start && mat_valid) begin
               state_d = READ;
               entry_d = 4'd0;
            end
         end
         READ: begin
            if (last_beat) begin
               state_d   = IDLE;
               entry_d   = 4'd0;
               rd_bank_d = ~rd_bank_q;
            end else begin
               entry_d = entry_q + 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
            entry_d = 4'd0;
         end
      endcase
   end

   // bank occupancy: a frame completion and a release in one cycle cancel out
   always_comb begin
      full_cnt_d = full_cnt_q;
      case ({fd_accept, last_beat})
         2'b10:   full_cnt_d = full_cnt_q + 2'd1;
         2'b01:   full_cnt_d = full_cnt_q - 2'd1;
         default: full_cnt_d = full_cnt_q;
      endcase
      wr_bank_d = wr_bank_q ^ fd_accept;
      ovf_d     = ovf_q | ((bus.in_wr_en | bus.in_frame_done) & ~ready);
   end

   // control state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         entry_q    <= 4'd0;
         rd_bank_q  <= 1'b0;
         wr_bank_q  <= 1'b0;
         full_cnt_q <= 2'd0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         entry_q    <= entry_d;
         rd_bank_q  <= rd_bank_d;
         wr_bank_q  <= wr_bank_d;
         full_cnt_q <= full_cnt_d;
         ovf_q      <= ovf_d;
      end
   end

   // registered write pass-through; the address uses the pre-toggle wr_bank
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bank_wr_en_q   <= 1'b0;
         bank_wr_strb_q <= '0;
         bank_wr_addr_q <= 5'd0;
         bank_wr_data_q <= '0;
      end else if (wr_accept) begin
         bank_wr_en_q   <= 1'b1;
         bank_wr_strb_q <= bus.in_wr_strb;
         bank_wr_addr_q <= {wr_bank_q, bus.in_wr_addr};
         bank_wr_data_q <= bus.in_wr_data;
      end else begin
         bank_wr_en_q   <= 1'b0;
         bank_wr_strb_q <= '0;
         bank_wr_addr_q <= 5'd0;
         bank_wr_data_q <= '0;
      end
   end
endmodule
